// File: rtl/fft_seq_core_if.sv
// ---------------------------------------------------------------------------
// fft_seq_core_if
// Stream bundle for the sequential FFT engine: a real-sample input stream and
// a complex-bin output stream, both valid/ready.
//   in_valid  : upstream has a sample on in_d
//   in_ready  : engine accepts samples (LOAD only)
//   in_d      : signed Q8.8 real sample
//   out_valid : out_d holds a bin
//   out_ready : downstream consumes the bin
//   out_d     : {real[23:8], imag[23:8]} of the internal Q16.16 bin word
//   out_idx   : natural-order bin index of out_d
//   out_last  : high together with bin N-1
// Modports: slave = engine side, master = upstream/downstream side.
// ---------------------------------------------------------------------------
interface fft_seq_core_if #(
    parameter int N = 16
);
    localparam int IW = $clog2(N);

    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_d;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_d;
    logic [IW-1:0] out_idx;
    logic          out_last;

    modport slave (
        input  in_valid, in_d, out_ready,
        output in_ready, out_valid, out_d, out_idx, out_last
    );

    modport master (
        output in_valid, in_d, out_ready,
        input  in_ready, out_valid, out_d, out_idx, out_last
    );
endinterface

// File: rtl/fft_seq_core.sv
// ---------------------------------------------------------------------------
// fft_seq_core
// Sequential radix-2 DIT FFT. Loads N real samples in bit-reversed order,
// runs log2(N) stages of N/2 butterflies (one butterfly per clock) in place,
// then streams the N complex bins out in natural order.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : stream bundle (fft_seq_core_if.slave)
//   busy  : high while computing or emitting bins (= !in_ready)
// Parameters:
//   N     : FFT length, power of two, 8..64
//   SCALE : 1 = arithmetic shift right by 1 after every stage
// ---------------------------------------------------------------------------
module fft_seq_core #(
    parameter int N     = 16,
    parameter int SCALE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    fft_seq_core_if.slave bus,
    output logic          busy
);
    localparam int IW = $clog2(N);      // sample / bin index width
    localparam int HW = IW - 1;         // butterfly index width (N/2 per stage)
    localparam int SW = $clog2(IW);     // stage counter width

    localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
    localparam logic [HW-1:0] LAST_BFLY  = HW'(N / 2 - 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(IW - 1);

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_OUTPUT  = 2'd2;

    localparam real PI = 3.14159265358979323846;

    // Q16.16 conversion with round-to-nearest (ties away from zero).
    function automatic logic [31:0] to_q16(input real x);
        real v;
        v = x * 65536.0;
        if (v >= 0.0) to_q16 = 32'($rtoi(v + 0.5));
        else          to_q16 = 32'(-$rtoi(-v + 0.5));
    endfunction

    function automatic logic [IW-1:0] bit_rev(input logic [IW-1:0] v);
        logic [IW-1:0] r;
        for (int i = 0; i < IW; i++) r[i] = v[IW-1-i];
        return r;
    endfunction

    // Signed Q16.16 multiply on magnitudes: round product at bit 15, then
    // re-apply the sign. (p >> 15) + 1, halved, equals p[47:16] + p[15].
    function automatic logic [31:0] qmul(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] mx, my, r;
        logic [32:0] s;
        mx = x[31] ? (~x + 32'd1) : x;
        my = y[31] ? (~y + 32'd1) : y;
        s  = 33'((48'(mx) * 48'(my)) >> 15) + 33'd1;
        r  = 32'(s >> 1);
        return (x[31] ^ y[31]) ? (~r + 32'd1) : r;
    endfunction

    // ------------------------------------------------------------------
    // Twiddle ROM: cos/sin(2*pi*k/N), k = 0..N/2-1, fixed at elaboration
    // ------------------------------------------------------------------
    logic [31:0] tw_cos [N/2];
    logic [31:0] tw_sin [N/2];

    generate
        for (genvar gi = 0; gi < N / 2; gi++) begin : g_tw
            localparam real ANG = 2.0 * PI * real'(gi) / real'(N);
            assign tw_cos[gi] = to_q16($cos(ANG));
            assign tw_sin[gi] = to_q16($sin(ANG));
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]    state_q, state_d;
    logic [IW-1:0] cnt_q,   cnt_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [HW-1:0] bfly_q,  bfly_d;
    logic [IW-1:0] oidx_q,  oidx_d;

    // Working array; two reads and two writes per butterfly cycle.
    logic [31:0] re_q [N];
    logic [31:0] im_q [N];

    logic          in_ready_w;
    logic          out_valid_w;
    logic          ld_we, bf_we;
    logic [IW-1:0] a_idx, b_idx, j_ext, lo_mask;
    logic [HW-1:0] k_idx;
    logic [31:0]   wr, wi, tr, ti;
    logic [31:0]   sum_ar, sum_ai, dif_br, dif_bi;
    logic [31:0]   new_ar, new_ai, new_br, new_bi;

    assign in_ready_w  = (state_q == ST_LOAD);
    assign out_valid_w = (state_q == ST_OUTPUT);

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        bfly_d  = bfly_q;
        oidx_d  = oidx_q;
        ld_we   = 1'b0;
        bf_we   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (bus.in_valid) begin
                    ld_we = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_COMPUTE;
                        cnt_d   = '0;
                        stage_d = '0;
                        bfly_d  = '0;
                    end
                end
            end
            ST_COMPUTE: begin
                bf_we  = 1'b1;
                bfly_d = bfly_q + 1'b1;
                if (bfly_q == LAST_BFLY) begin
                    bfly_d  = '0;
                    stage_d = stage_q + 1'b1;
                    if (stage_q == LAST_STAGE) begin
                        state_d = ST_OUTPUT;
                        stage_d = '0;
                        oidx_d  = '0;
                    end
                end
            end
            ST_OUTPUT: begin
                if (bus.out_ready) begin
                    oidx_d = oidx_q + 1'b1;
                    if (oidx_q == LAST_IDX) begin
                        state_d = ST_LOAD;
                        oidx_d  = '0;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            stage_q <= '0;
            bfly_q  <= '0;
            oidx_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
            oidx_q  <= oidx_d;
        end
    end

    // ------------------------------------------------------------------
    // Butterfly addressing: butterfly j of stage s has a = j with a zero
    // inserted at bit s (group bits shifted up, offset bits kept), b = a + 2^s,
    // and twiddle index k = offset << (log2N - 1 - s).
    // ------------------------------------------------------------------
    always_comb begin
        j_ext   = {1'b0, bfly_q};
        lo_mask = (IW'(1) << stage_q) - IW'(1);
        a_idx   = ((j_ext & ~lo_mask) << 1) | (j_ext & lo_mask);
        b_idx   = a_idx | (IW'(1) << stage_q);
        k_idx   = HW'((j_ext & lo_mask) << (LAST_STAGE - stage_q));
    end

    // W = cos - j*sin; t = W * b; a' = a + t; b' = a - t (all wrapping).
    always_comb begin
        wr     = tw_cos[k_idx];
        wi     = ~tw_sin[k_idx] + 32'd1;
        tr     = qmul(wr, re_q[b_idx]) - qmul(wi, im_q[b_idx]);
        ti     = qmul(wr, im_q[b_idx]) + qmul(wi, re_q[b_idx]);
        sum_ar = re_q[a_idx] + tr;
        sum_ai = im_q[a_idx] + ti;
        dif_br = re_q[a_idx] - tr;
        dif_bi = im_q[a_idx] - ti;
        if (SCALE != 0) begin
            new_ar = {sum_ar[31], sum_ar[31:1]};
            new_ai = {sum_ai[31], sum_ai[31:1]};
            new_br = {dif_br[31], dif_br[31:1]};
            new_bi = {dif_bi[31], dif_bi[31:1]};
        end else begin
            new_ar = sum_ar;
            new_ai = sum_ai;
            new_br = dif_br;
            new_bi = dif_bi;
        end
    end

    // Array contents need no reset; a new frame always overwrites all N words.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            re_q[bit_rev(cnt_q)] <= {{8{bus.in_d[15]}}, bus.in_d, 8'h00};
            im_q[bit_rev(cnt_q)] <= '0;
        end else if (bf_we) begin
            re_q[a_idx] <= new_ar;
            im_q[a_idx] <= new_ai;
            re_q[b_idx] <= new_br;
            im_q[b_idx] <= new_bi;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: the array is frozen in OUTPUT, so out_d is stable under stall.
    // ------------------------------------------------------------------
    assign bus.in_ready  = in_ready_w;
    assign busy          = !in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_idx   = oidx_q;
    assign bus.out_last  = out_valid_w && (oidx_q == LAST_IDX);
    assign bus.out_d     = out_valid_w ? {re_q[oidx_q][23:8], im_q[oidx_q][23:8]} : 32'd0;

endmodule

// File: tb/tb_fft_seq_core.sv
// ---------------------------------------------------------------------------
// tb_fft_seq_core
// Drives identical frames into an unscaled and a scaled engine (N=16).
// Expected bins come from a direct fixed-point DIT FFT computed on arrays;
// they are queued when a frame is issued and popped by per-engine monitors.
// ---------------------------------------------------------------------------
module tb_fft_seq_core;
    localparam int  N  = 16;
    localparam real PI = 3.14159265358979323846;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] d;
        logic        last;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy0, busy1;

    fft_seq_core_if #(.N(N)) bus0 ();
    fft_seq_core_if #(.N(N)) bus1 ();

    fft_seq_core #(.N(N), .SCALE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0), .busy(busy0));
    fft_seq_core #(.N(N), .SCALE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1));

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t exp0[$];
    exp_t exp1[$];
    logic [31:0] ref_bin3;

    logic hold_bp = 1'b0;
    logic rand_bp = 1'b0;
    logic rnd_rdy = 1'b1;

    assign bus0.out_ready = hold_bp ? 1'b0 : rnd_rdy;
    assign bus1.out_ready = hold_bp ? 1'b0 : rnd_rdy;

    initial forever begin
        @(posedge clk);
        #1;
        rnd_rdy = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] q16(input real x);
        real v;
        v = x * 65536.0;
        if (v >= 0.0) return 32'($rtoi(v + 0.5));
        return 32'(-$rtoi(-v + 0.5));
    endfunction

    function automatic logic [31:0] fxmul(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] mx, my, r;
        logic [63:0] p;
        mx = x[31] ? -x : x;
        my = y[31] ? -y : y;
        p  = 64'(mx) * 64'(my);
        r  = p[47:16] + {31'b0, p[15]};
        return (x[31] ^ y[31]) ? -r : r;
    endfunction

    function automatic int brev4(input int i);
        return ((i & 1) << 3) | ((i & 2) << 1) | ((i & 4) >> 1) | ((i & 8) >> 3);
    endfunction

    task automatic ref_fft(input logic [15:0] s[N], input bit sc, output logic [31:0] o[N]);
        logic [31:0] xr[N], xi[N];
        logic [31:0] wr, wi, tr, ti, ar, ai, br, bi;
        for (int i = 0; i < N; i++) begin
            xr[brev4(i)] = {{8{s[i][15]}}, s[i], 8'h00};
            xi[brev4(i)] = 32'd0;
        end
        for (int st = 0; st < 4; st++) begin
            int h;
            h = 1 << st;
            for (int g = 0; g < N; g += 2 * h) begin
                for (int off = 0; off < h; off++) begin
                    int a, b, k;
                    a  = g + off;
                    b  = a + h;
                    k  = off * (N / (2 * h));
                    wr = q16($cos(2.0 * PI * real'(k) / real'(N)));
                    wi = -q16($sin(2.0 * PI * real'(k) / real'(N)));
                    tr = fxmul(wr, xr[b]) - fxmul(wi, xi[b]);
                    ti = fxmul(wr, xi[b]) + fxmul(wi, xr[b]);
                    ar = xr[a] + tr;
                    ai = xi[a] + ti;
                    br = xr[a] - tr;
                    bi = xi[a] - ti;
                    if (sc) begin
                        ar = $signed(ar) >>> 1;
                        ai = $signed(ai) >>> 1;
                        br = $signed(br) >>> 1;
                        bi = $signed(bi) >>> 1;
                    end
                    xr[a] = ar; xi[a] = ai; xr[b] = br; xi[b] = bi;
                end
            end
        end
        for (int i = 0; i < N; i++) o[i] = {xr[i][23:8], xi[i][23:8]};
    endtask

    // ---------------- monitors ----------------
    task automatic mon_bin(input int u, input logic [3:0] idx, input logic [31:0] d, input logic last);
        exp_t e;
        if ((u == 0 && exp0.size() == 0) || (u == 1 && exp1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexpected_bin dut%0d: got idx=%0d expected no output", u, idx);
            return;
        end
        if (u == 0) e = exp0.pop_front();
        else        e = exp1.pop_front();
        $display("dut%0d bin idx=%0d d=%08h last=%0b (exp %08h)", u, idx, d, last, e.d);
        chk($sformatf("dut%0d_out_idx", u), idx, e.idx);
        chk($sformatf("dut%0d_out_d[%0d]", u, e.idx), d, e.d);
        chk($sformatf("dut%0d_out_last[%0d]", u, e.idx), last, e.last);
    endtask

    always @(negedge clk)
        if (rst_n && bus0.out_valid && bus0.out_ready)
            mon_bin(0, bus0.out_idx, bus0.out_d, bus0.out_last);

    always @(negedge clk)
        if (rst_n && bus1.out_valid && bus1.out_ready)
            mon_bin(1, bus1.out_idx, bus1.out_d, bus1.out_last);

    // ---------------- stimulus ----------------
    task automatic drive_in(input logic v, input logic [15:0] d);
        bus0.in_valid = v; bus0.in_d = d;
        bus1.in_valid = v; bus1.in_d = d;
    endtask

    // Sends one frame; returns at the negedge after the last accept, or,
    // with lat set, at the first negedge showing out_valid.
    task automatic send_frame(input logic [15:0] s[N], input bit push, input bit junk, input bit lat);
        logic [31:0] r0[N], r1[N];
        exp_t e;
        bit   rdy;
        int   n, cyc;
        if (push) begin
            ref_fft(s, 1'b0, r0);
            ref_fft(s, 1'b1, r1);
            for (int i = 0; i < N; i++) begin
                e.idx = 4'(i); e.last = (i == N - 1);
                e.d = r0[i]; exp0.push_back(e);
                e.d = r1[i]; exp1.push_back(e);
            end
            ref_bin3 = r0[3];
        end
        for (int i = 0; i < N; i++) begin
            drive_in(1'b1, s[i]);
            n = 0;
            do begin
                @(negedge clk);
                rdy = bus0.in_ready;
                n++;
                @(posedge clk);
                #1;
            end while (!rdy && n < 2000);
            if (!rdy) begin
                total++; bad++;
                $display("FAIL in_accept_timeout: got in_ready=0 expected 1 within 2000 cycles");
                drive_in(1'b0, 16'h0);
                return;
            end
        end
        drive_in(junk, junk ? 16'($urandom) : 16'h0);
        @(negedge clk);
        chk("in_ready_fall", bus0.in_ready, 1'b0);
        chk("busy_rise", busy0, 1'b1);
        if (lat) begin
            cyc = 0;
            while (!bus0.out_valid && cyc < 200) begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
                if (!bus0.out_valid) chk("in_ready_compute", bus0.in_ready, 1'b0);
            end
            chk("first_out_latency", cyc, 32);
            chk("scaled_out_valid_sync", bus1.out_valid, 1'b1);
        end
    endtask

    initial begin
        logic [15:0] s[N];
        int n;
        drive_in(1'b0, 16'h0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus0.in_ready, 1'b1);
        chk("rst_out_valid", bus0.out_valid, 1'b0);
        chk("rst_out_d", bus0.out_d, 32'h0);
        chk("rst_out_idx", bus0.out_idx, 4'h0);
        chk("rst_out_last", bus0.out_last, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_busy_scaled", busy1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // DC frame with latency check
        for (int i = 0; i < N; i++) s[i] = 16'h0100;
        send_frame(s, 1'b1, 1'b0, 1'b1);

        // Impulse
        for (int i = 0; i < N; i++) s[i] = (i == 0) ? 16'h0100 : 16'h0000;
        send_frame(s, 1'b1, 1'b0, 1'b0);

        // Nyquist
        for (int i = 0; i < N; i++) s[i] = i[0] ? 16'hFF00 : 16'h0100;
        send_frame(s, 1'b1, 1'b0, 1'b0);

        // Random frame, in_valid held during COMPUTE/OUTPUT, stall at bin 3
        for (int i = 0; i < N; i++) s[i] = 16'($urandom);
        send_frame(s, 1'b1, 1'b1, 1'b1);
        n = 0;
        while (!(bus0.out_valid && bus0.out_idx == 4'd2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_bin2", bus0.out_idx, 4'd2);
        @(posedge clk);
        #1;
        hold_bp = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_out_valid", bus0.out_valid, 1'b1);
            chk("stall_out_idx", bus0.out_idx, 4'd3);
            chk("stall_out_d", bus0.out_d, ref_bin3);
            chk("stall_in_ready", bus0.in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        hold_bp = 1'b0;
        drive_in(1'b0, 16'h0);

        // Reset in the middle of COMPUTE discards the frame
        for (int i = 0; i < N; i++) s[i] = 16'h0100;
        send_frame(s, 1'b0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("busy_before_reset", busy0, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", bus0.in_ready, 1'b1);
        chk("midrst_busy", busy0, 1'b0);
        chk("midrst_out_valid", bus0.out_valid, 1'b0);
        chk("midrst_out_d", bus0.out_d, 32'h0);
        chk("midrst_out_idx", bus0.out_idx, 4'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(s, 1'b1, 1'b0, 1'b1);

        // Random frames under random output backpressure
        rand_bp = 1'b1;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) s[i] = 16'($urandom);
            send_frame(s, 1'b1, 1'b0, 1'b0);
        end

        n = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending_bins", exp0.size() + exp1.size(), 0);
        rand_bp = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
